// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CORE has fixed priority, with a starvation guard that forces a DMA grant.
// Optional transaction/wait-state statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]     stat_core_cnt,
    output logic [31:0]     stat_dma_cnt,
    output logic [31:0]     stat_wait_cnt,
`endif
    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    input  logic [DW/8-1:0] core_wstrb,
    output logic            core_gnt,
    output logic            core_done,
    output logic [DW-1:0]   core_rdata,
    output logic            core_stall,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [AW-1:0]   dma_addr,
    input  logic [DW-1:0]   dma_wdata,
    input  logic [DW/8-1:0] dma_wstrb,
    output logic            dma_gnt,
    output logic            dma_done,
    output logic [DW-1:0]   dma_rdata,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, CORE_BUSY, DMA_BUSY} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            mem_valid_q, mem_valid_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic            core_gnt_q, core_gnt_d, core_done_q, core_done_d;
    logic            dma_gnt_q, dma_gnt_d, dma_done_q, dma_done_d;
    logic [DW-1:0]   core_rdata_q, core_rdata_d, dma_rdata_q, dma_rdata_d;
    logic            dma_win;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]     core_cnt_q, core_cnt_d, dma_cnt_q, dma_cnt_d, wait_cnt_q, wait_cnt_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            core_gnt_q   <= 1'b0;
            core_done_q  <= 1'b0;
            core_rdata_q <= '0;
            dma_gnt_q    <= 1'b0;
            dma_done_q   <= 1'b0;
            dma_rdata_q  <= '0;
`ifdef DMEM_ARB_STATS_EN
            core_cnt_q   <= '0;
            dma_cnt_q    <= '0;
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            core_gnt_q   <= core_gnt_d;
            core_done_q  <= core_done_d;
            core_rdata_q <= core_rdata_d;
            dma_gnt_q    <= dma_gnt_d;
            dma_done_q   <= dma_done_d;
            dma_rdata_q  <= dma_rdata_d;
`ifdef DMEM_ARB_STATS_EN
            core_cnt_q   <= core_cnt_d;
            dma_cnt_q    <= dma_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    // DMA overrides CORE priority once the starvation counter hits the limit
    assign dma_win = dma_req & (~core_req | (starve_q == LIMIT));

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        core_gnt_d   = 1'b0;
        core_done_d  = 1'b0;
        core_rdata_d = core_rdata_q;
        dma_gnt_d    = 1'b0;
        dma_done_d   = 1'b0;
        dma_rdata_d  = dma_rdata_q;
`ifdef DMEM_ARB_STATS_EN
        core_cnt_d   = core_cnt_q;
        dma_cnt_d    = dma_cnt_q;
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (dma_win) begin
                    state_d     = DMA_BUSY;
                    dma_gnt_d   = 1'b1;
                    mem_valid_d = 1'b1;
                    mem_we_d    = dma_we;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                    mem_wstrb_d = dma_we ? dma_wstrb : '0;
                    starve_d    = '0;
                end else if (core_req) begin
                    state_d     = CORE_BUSY;
                    core_gnt_d  = 1'b1;
                    mem_valid_d = 1'b1;
                    mem_we_d    = core_we;
                    mem_addr_d  = core_addr;
                    mem_wdata_d = core_wdata;
                    mem_wstrb_d = core_we ? core_wstrb : '0;
                    if (!dma_req) begin
                        starve_d = '0;
                    end else if (starve_q != LIMIT) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (!dma_req) begin
                    starve_d = '0;
                end
            end
            CORE_BUSY: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    core_done_d = 1'b1;
                    if (!mem_we_q) core_rdata_d = mem_rdata;
`ifdef DMEM_ARB_STATS_EN
                    core_cnt_d  = core_cnt_q + 32'd1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 32'd1;
`endif
                end
            end
            DMA_BUSY: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    dma_done_d  = 1'b1;
                    if (!mem_we_q) dma_rdata_d = mem_rdata;
`ifdef DMEM_ARB_STATS_EN
                    dma_cnt_d   = dma_cnt_q + 32'd1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 32'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign core_gnt   = core_gnt_q;
    assign core_done  = core_done_q;
    assign core_rdata = core_rdata_q;
    assign core_stall = core_req & ~core_done_q;
    assign dma_gnt    = dma_gnt_q;
    assign dma_done   = dma_done_q;
    assign dma_rdata  = dma_rdata_q;
`ifdef DMEM_ARB_STATS_EN
    assign stat_core_cnt = core_cnt_q;
    assign stat_dma_cnt  = dma_cnt_q;
    assign stat_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (AW=DW=32, STARVE_LIMIT=4).
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, dma_req, dma_we, mem_ready;
    logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [3:0]  core_wstrb, dma_wstrb;
    logic        core_gnt, core_done, core_stall, dma_gnt, dma_done;
    logic        mem_valid, mem_we;
    logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_core_cnt, stat_dma_cnt, stat_wait_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
`ifdef DMEM_ARB_STATS_EN
        .stat_core_cnt(stat_core_cnt), .stat_dma_cnt(stat_dma_cnt), .stat_wait_cnt(stat_wait_cnt),
`endif
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wstrb(core_wstrb),
        .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    string exp_seq;
    int    n_gnt;

    initial begin
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_wstrb = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
        tick(); tick();
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_core_gnt", 32'(core_gnt), 0);
        check("rst_dma_done", 32'(dma_done), 0);
        check("rst_core_rdata", core_rdata, 0);
        reset = 1'b0;

        // 1: CORE load, zero wait
        core_req = 1; core_we = 0; core_addr = 32'h100; core_wstrb = 4'hF;
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        #1 check("t1_stall_c0", 32'(core_stall), 1);
        tick();
        check("t1_gnt_c1", 32'(core_gnt), 1);
        check("t1_valid_c1", 32'(mem_valid), 1);
        check("t1_addr_c1", mem_addr, 32'h100);
        check("t1_wstrb_load", 32'(mem_wstrb), 0);
        check("t1_stall_c1", 32'(core_stall), 1);
        tick();
        check("t1_done_c2", 32'(core_done), 1);
        check("t1_rdata_c2", core_rdata, 32'hDEADBEEF);
        check("t1_valid_c2", 32'(mem_valid), 0);
        check("t1_stall_c2", 32'(core_stall), 0);
        core_req = 0;
        tick();
        check("t1_done_c3", 32'(core_done), 0);
        check("t1_nogrant_c3", 32'(core_gnt), 0);

        // 2: DMA store with 3 wait states
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678; dma_wstrb = 4'hF;
        mem_ready = 0; mem_rdata = 32'hCAFEF00D;
        tick();
        check("t2_gnt", 32'(dma_gnt), 1);
        dma_req = 0;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("t2_valid_w%0d", w), 32'(mem_valid), 1);
            check($sformatf("t2_addr_w%0d", w), mem_addr, 32'h40);
            check($sformatf("t2_wdata_w%0d", w), mem_wdata, 32'h12345678);
            check($sformatf("t2_wstrb_w%0d", w), 32'(mem_wstrb), 32'hF);
            check($sformatf("t2_done_w%0d", w), 32'(dma_done), 0);
            tick();
        end
        check("t2_valid_last", 32'(mem_valid), 1);
        check("t2_we_last", 32'(mem_we), 1);
        mem_ready = 1;
        tick();
        check("t2_done", 32'(dma_done), 1);
        check("t2_valid_off", 32'(mem_valid), 0);
        check("t2_dma_rdata", dma_rdata, 0);
        check("t2_core_rdata", core_rdata, 32'hDEADBEEF);
        mem_ready = 0;
        tick();
        check("t2_done_pulse", 32'(dma_done), 0);
`ifdef DMEM_ARB_STATS_EN
        check("t6_core_cnt", stat_core_cnt, 1);
        check("t6_dma_cnt", stat_dma_cnt, 1);
        check("t6_wait_cnt", stat_wait_cnt, 3);
`endif

        // 3: both held continuously, zero wait
        core_req = 1; core_we = 0; core_addr = 32'h200;
        dma_req = 1; dma_we = 1; dma_addr = 32'h300; dma_wstrb = 4'h3;
        mem_ready = 1;
        exp_seq = "CCCCDCCCCD";
        n_gnt = 0;
        for (int cyc = 0; cyc < 40 && n_gnt < 10; cyc++) begin
            tick();
            if (core_gnt && dma_gnt) check("t3_dual_gnt", 1, 0);
            if (core_gnt) begin
                check($sformatf("t3_order%0d", n_gnt), 32'("C"), 32'(exp_seq[n_gnt]));
                check($sformatf("t3_addr%0d", n_gnt), mem_addr, 32'h200);
                n_gnt++;
            end else if (dma_gnt) begin
                check($sformatf("t3_order%0d", n_gnt), 32'("D"), 32'(exp_seq[n_gnt]));
                check($sformatf("t3_addr%0d", n_gnt), mem_addr, 32'h300);
                n_gnt++;
            end
        end
        if (n_gnt < 10) check("t3_grant_count", 32'(n_gnt), 10);
        core_req = 0; dma_req = 0;
        tick(); tick();

        // 4: simultaneous request with starve_cnt=0
        core_addr = 32'h400; core_we = 0;
        dma_addr = 32'h500; dma_we = 0;
        mem_rdata = 32'h0BADF00D; mem_ready = 1;
        core_req = 1; dma_req = 1;
        tick();
        check("t4_core_gnt", 32'(core_gnt), 1);
        check("t4_dma_gnt_e1", 32'(dma_gnt), 0);
        check("t4_addr_e1", mem_addr, 32'h400);
        core_req = 0;
        tick();
        check("t4_core_done", 32'(core_done), 1);
        check("t4_core_rdata", core_rdata, 32'h0BADF00D);
        check("t4_dma_gnt_e2", 32'(dma_gnt), 0);
        mem_rdata = 32'h11223344;
        tick();
        check("t4_dma_gnt_e3", 32'(dma_gnt), 1);
        check("t4_addr_e3", mem_addr, 32'h500);
        check("t4_wstrb_load", 32'(mem_wstrb), 0);
        dma_req = 0;
        tick();
        check("t4_dma_done", 32'(dma_done), 1);
        check("t4_dma_rdata", dma_rdata, 32'h11223344);
        mem_ready = 0;
        tick();

        // 5: reset during a DMA wait state
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'hAAAA5555; dma_wstrb = 4'hC;
        tick();
        check("t5_gnt", 32'(dma_gnt), 1);
        dma_req = 0;
        tick();
        check("t5_busy_valid", 32'(mem_valid), 1);
        check("t5_busy_wstrb", 32'(mem_wstrb), 32'hC);
        reset = 1;
        #1;
        check("t5_rst_valid", 32'(mem_valid), 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_wstrb", 32'(mem_wstrb), 0);
        check("t5_rst_we", 32'(mem_we), 0);
        check("t5_rst_core_rdata", core_rdata, 0);
        check("t5_rst_dma_rdata", dma_rdata, 0);
        mem_ready = 1;
        tick();
        check("t5_rst_done", 32'(dma_done), 0);
        reset = 0;
        tick();
        check("t5_post_done", 32'(dma_done), 0);
        check("t5_post_valid", 32'(mem_valid), 0);
        core_req = 1; core_we = 0; core_addr = 32'h600;
        tick();
        check("t5_idle_gnt", 32'(core_gnt), 1);
        core_req = 0;
        tick();
        check("t5_idle_done", 32'(core_done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
